// File: rtl/tetris_pkg.sv
// Shared piece definitions and queue types used across the tetris blocks.
package tetris_pkg;

    typedef enum logic [2:0] {
        PIECE_I    = 3'd0,
        PIECE_O    = 3'd1,
        PIECE_T    = 3'd2,
        PIECE_S    = 3'd3,
        PIECE_Z    = 3'd4,
        PIECE_J    = 3'd5,
        PIECE_L    = 3'd6,
        PIECE_NONE = 3'd7
    } piece_t;

    localparam int QUEUE_DEPTH = 4;

    typedef struct packed {
        logic   valid;
        logic   forced;
        piece_t piece;
    } push_t;

endpackage

// File: rtl/piece_prio_enc.sv
// Finds the lowest-index piece whose bag mask bit is still clear.
module piece_prio_enc
    import tetris_pkg::*;
(
    input  logic [6:0] mask,
    output piece_t     idx
);

    // Scan high to low so the lowest clear bit wins; all-set yields NONE.
    always_comb begin
        idx = PIECE_NONE;
        for (int i = 6; i >= 0; i--) begin
            if (!mask[i]) idx = piece_t'(3'(i));
        end
    end

endmodule

// File: rtl/piece_queue.sv
// 7-bag piece queue: head plus three previews, random fill with a forced
// fallback after too many rejected samples.
module piece_queue
    import tetris_pkg::*;
#(
    parameter int SKIP_LIMIT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] rand_in,
    input  logic       take,
    output logic       piece_valid,
    output logic [2:0] piece,
    output logic [2:0] preview0,
    output logic [2:0] preview1,
    output logic [2:0] preview2,
    output logic       bag_done,
    output logic       forced
);

    piece_t      slots   [QUEUE_DEPTH];
    piece_t      n_slots [QUEUE_DEPTH];
    logic [2:0]  count, n_count;
    logic [6:0]  mask, n_mask, mask_set;
    logic [7:0]  streak, n_streak;
    logic [7:0]  mask_ext;
    piece_t      free_piece;
    push_t       push;
    logic        opp, accept, at_limit, pop, bag_full;

    piece_prio_enc u_enc (
        .mask (mask),
        .idx  (free_piece)
    );

    always_comb begin
        // Bit 7 is permanently "used" so the invalid index never accepts.
        mask_ext    = {1'b1, mask};
        opp         = (count != 3'(QUEUE_DEPTH)) || take;
        accept      = !mask_ext[rand_in];
        at_limit    = (streak == 8'(SKIP_LIMIT - 1));
        pop         = take && (count != 3'd0);

        push.valid  = opp && (accept || at_limit);
        push.forced = opp && !accept && at_limit;
        push.piece  = accept ? piece_t'(rand_in) : free_piece;

        mask_set    = mask | (7'd1 << push.piece);
        bag_full    = push.valid && (mask_set == 7'h7F);

        n_mask = mask;
        if (push.valid) n_mask = bag_full ? 7'd0 : mask_set;

        n_streak = streak;
        if (push.valid)
            n_streak = 8'd0;
        else if (opp)
            n_streak = streak + 8'd1;

        n_slots = slots;
        n_count = count;
        if (pop) begin
            for (int i = 0; i < QUEUE_DEPTH - 1; i++) n_slots[i] = slots[i + 1];
            n_slots[QUEUE_DEPTH - 1] = PIECE_NONE;
            n_count = count - 3'd1;
        end
        // After any pop the tail index is below depth, so this write is in range.
        if (push.valid) begin
            n_slots[n_count[1:0]] = push.piece;
            n_count = n_count + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) slots[i] <= PIECE_NONE;
            count  <= 3'd0;
            mask   <= 7'd0;
            streak <= 8'd0;
        end else begin
            slots  <= n_slots;
            count  <= n_count;
            mask   <= n_mask;
            streak <= n_streak;
        end
    end

    assign piece_valid = (count != 3'd0);
    assign piece       = slots[0];
    assign preview0    = slots[1];
    assign preview1    = slots[2];
    assign preview2    = slots[3];
    assign bag_done    = bag_full && !reset;
    assign forced      = push.forced && !reset;

endmodule

// File: doc/piece_queue.md
PIECE_QUEUE -- requirements
Module: piece_queue

Interface
REQ-001 SHALL have parameter SKIP_LIMIT, default 15; consecutive rejected random samples before a forced fill (range 1..255).
REQ-002 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port rand_in  input  3  raw piece index from the random generator, sampled every cycle; 0..6 valid, 7 invalid.
REQ-005 SHALL have port take  input  1  game logic consumes the head piece this cycle.
REQ-006 SHALL have port piece_valid  output  1  head slot holds a piece.
REQ-007 SHALL have port piece  output  3  head piece index; 7 when empty.
REQ-008 SHALL have port preview0/preview1/preview2  output  3 each  queue slots 1..3; 7 when the slot is empty.
REQ-009 SHALL have port bag_done  output  1  one-cycle pulse when the 7th distinct piece of a bag is accepted.
REQ-010 SHALL have port forced  output  1  one-cycle pulse when a push came from the forced-fill path.

Function
REQ-011 SHALL hold a 4-entry in-order queue (head plus 3 previews) with a 3-bit count 0..4.
REQ-012 SHALL keep a 7-bit used mask for the current bag; a sample is accepted only if it is 0..6 and its mask bit is clear.
REQ-013 SHALL have a push opportunity when count<4, or count==4 and take is high.
REQ-014 SHALL push at most one piece per cycle; a pushed piece is visible on outputs the cycle after the edge (latency 1).
REQ-015 SHALL pop when take is high and count>0; take while empty is ignored with no state change.
REQ-016 SHALL perform pop and push in the same cycle, including when full; count stays unchanged and slots shift by one.
REQ-017 SHALL set the mask bit of an accepted piece; if the mask would become 7'h7F, it SHALL instead clear to 0 and bag_done SHALL pulse.
REQ-018 SHALL increment the reject streak counter on each push opportunity whose sample is rejected; it SHALL hold when there is no opportunity and clear on any push.
REQ-019 SHALL, when the streak equals SKIP_LIMIT-1 and the sample is rejected, push the lowest-index unused piece instead; forced SHALL pulse and the mask SHALL update as in REQ-017.
REQ-020 SHALL derive piece_valid as count!=0 and drive empty slot outputs to 7.
REQ-021 SHALL never hold two equal pieces from the same bag simultaneously in the queue.

Reset
REQ-022 SHALL, on reset, set count 0, all slots 7, mask 0, streak 0, and piece_valid, bag_done and forced to 0.
REQ-023 SHALL give reset priority over take and push in the same cycle; a mid-bag reset SHALL discard the queue and start a fresh bag.

Structure
REQ-024 SHALL take piece_t (I=0,O=1,T=2,S=3,Z=4,J=5,L=6), PIECE_NONE=7 and QUEUE_DEPTH=4 from the shared package tetris_pkg.
REQ-025 SHALL place the lowest-clear-bit search over the mask in the sub-module piece_prio_enc (7-bit mask in, 3-bit index out).
REQ-026 SHALL implement the block as registers plus combinational next-state logic in 120-400 lines.

Verification
REQ-027 SHALL cover: reset, then rand_in 3,3,5,0,1 with take=0 -> piece=3, preview0..2=5,0,1 once full; second 3 is rejected; no push while full.
REQ-028 SHALL cover: full queue, take=1 with rand_in=2 for one cycle -> next cycle piece=5, previews 0,1,2, count remains 4.
REQ-029 SHALL cover: feed 0..6 once each with take held high -> bag_done pulses on the cycle 6 is accepted and the mask returns to 0.
REQ-030 SHALL cover: rand_in held at 7 with an empty queue, SKIP_LIMIT=15 -> forced pulses on the 15th cycle, piece=0 the next cycle, and the streak restarts.
REQ-031 SHALL cover: take on an empty queue -> no change; reset asserted with count 3 and a take pending -> next cycle count 0, all outputs 7, piece_valid 0.
